// File: rtl/if0_pcgen_pkg.sv
// Front-end shared definitions: fetch defaults, IF0 state encoding and the
// fetch-group record passed from the group calculator to the IF0 output stage.
package if0_pcgen_pkg;

    localparam int          DEF_FETCH_WIDTH = 2;
    localparam int          MAX_FETCH_WIDTH = 8;
    localparam logic [31:0] DEF_RESET_PC    = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if0_state_e;

    // mask is sized for the widest supported group; narrower users take the
    // low FETCH_WIDTH bits, the rest are always zero.
    typedef struct packed {
        logic [31:0]                pc;
        logic [MAX_FETCH_WIDTH-1:0] mask;
        logic [31:0]                npc;
        logic                       adel;
    } fetch_group_t;

endpackage

// File: rtl/if_group_calc.sv
// Combinational fetch-group calculator: given a start PC, produces the slot
// valid mask, the next sequential (group-aligned) PC and the AdEL flag.
// Also used by IF1 to sanity-check predictor targets.
module if_group_calc
    import if0_pcgen_pkg::*;
#(
    parameter int FETCH_WIDTH = DEF_FETCH_WIDTH
) (
    input  logic [31:0]  p,
    output fetch_group_t grp
);

    localparam int          OFF       = $clog2(FETCH_WIDTH * 4);
    localparam logic [31:0] GRP_BYTES = 32'd1 << OFF;
    localparam logic [31:0] OFF_MASK  = GRP_BYTES - 32'd1;

    logic [31:0] base;
    logic [31:0] idx;
    logic        adel;

    // Align to the group, locate the first slot and build the slot mask.
    // A misaligned start only marks its own slot so IF1 sees a single
    // faulting instruction rather than a run of garbage fetches.
    always_comb begin
        base     = p & ~OFF_MASK;
        idx      = (p & OFF_MASK) >> 2;
        adel     = |p[1:0];
        grp      = '0;
        grp.pc   = p;
        grp.npc  = base + GRP_BYTES;
        grp.adel = adel;
        for (int i = 0; i < MAX_FETCH_WIDTH; i++) begin
            if (i < FETCH_WIDTH) begin
                grp.mask[i] = adel ? (idx == 32'(i)) : (32'(i) >= idx);
            end
        end
    end

endmodule

// File: rtl/if0_pcgen.sv
// IF0 fetch-PC generator: holds the sequential fetch PC, takes backend flushes
// and predictor redirects, and presents one registered fetch group to IF1
// over a valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// BOOT  | first cycle after reset; loads RESET_PC unless redirected
// RUN   | streaming sequential groups, redirects take effect next cycle
// HALT  | misaligned group issued; wait for a flush, ignore predictor
module if0_pcgen
    import if0_pcgen_pkg::*;
#(
    parameter int          FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter logic [31:0] RESET_PC    = DEF_RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_valid,
    input  logic [31:0]            flush_pc,
    input  logic                   bp_redirect_valid,
    input  logic [31:0]            bp_redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_pc,
    output logic [FETCH_WIDTH-1:0] out_mask,
    output logic [31:0]            out_npc,
    output logic                   out_adel
);

    if0_state_e   state;
    logic [31:0]  pc_q;
    logic [31:0]  sel_pc;
    logic         load;
    logic         adv;
    fetch_group_t grp;

    assign adv = !out_valid || out_ready;

    // Choose which address feeds the group calculator this cycle. Flush and
    // redirect load even when IF1 is stalled: the stalled group is stale.
    always_comb begin
        sel_pc = pc_q;
        load   = 1'b0;
        unique case (state)
            BOOT: begin
                load = 1'b1;
                if (flush_valid)            sel_pc = flush_pc;
                else if (bp_redirect_valid) sel_pc = bp_redirect_pc;
                else                        sel_pc = RESET_PC;
            end
            RUN: begin
                if (flush_valid) begin
                    load   = 1'b1;
                    sel_pc = flush_pc;
                end else if (bp_redirect_valid) begin
                    load   = 1'b1;
                    sel_pc = bp_redirect_pc;
                end else if (adv) begin
                    load   = 1'b1;
                    sel_pc = pc_q;
                end
            end
            HALT: begin
                if (flush_valid) begin
                    load   = 1'b1;
                    sel_pc = flush_pc;
                end
            end
            default: begin
                load   = 1'b0;
                sel_pc = pc_q;
            end
        endcase
    end

    if_group_calc #(
        .FETCH_WIDTH(FETCH_WIDTH)
    ) u_group_calc (
        .p  (sel_pc),
        .grp(grp)
    );

    // FSM, fetch PC and the IF1-facing output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc_q      <= RESET_PC;
            out_valid <= 1'b0;
            out_pc    <= RESET_PC;
            out_mask  <= '0;
            out_npc   <= '0;
            out_adel  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pc    <= grp.pc;
            out_mask  <= FETCH_WIDTH'(grp.mask);
            out_npc   <= grp.npc;
            out_adel  <= grp.adel;
            pc_q      <= grp.npc;
            state     <= grp.adel ? HALT : RUN;
        end else if (state == HALT && out_valid && out_ready) begin
            // faulting group consumed; nothing more until a flush
            out_valid <= 1'b0;
        end
    end

endmodule
